// File: rtl/aes_cipher_top.sv
// rtl/aes_cipher_top.sv - iterative AES-128 encrypt core, one round per clock, on-the-fly key expansion

// Forward AES S-box as a plain lookup table.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign y = SBOX[a];

endmodule

// Top-level cipher: loads on ld, runs rounds 1..10 on consecutive edges, pulses done.
module aes_cipher_top (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  output logic         done,
  input  logic [127:0] key,
  input  logic [127:0] text_in,
  output logic [127:0] text_out
);

  typedef enum logic {IDLE, RUN} fsm_t;

  fsm_t         fsm;
  logic [3:0]   round;
  logic [127:0] state;
  logic [127:0] rkey;

  logic [127:0] sub_bytes;
  logic [127:0] shift_rows;
  logic [127:0] mix_cols;
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [7:0]   rcon;
  logic [31:0]  w0_n, w1_n, w2_n, w3_n;
  logic [127:0] next_rkey;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // SubBytes on all 16 state bytes; byte i lives at bits [127-8i -: 8].
  for (genvar i = 0; i < 16; i++) begin : g_sub_bytes
    aes_sbox u_sbox (
      .a (state[127-8*i -: 8]),
      .y (sub_bytes[127-8*i -: 8])
    );
  end

  // ShiftRows: byte 4c+r takes the byte of row r from column (c+r) mod 4.
  for (genvar c = 0; c < 4; c++) begin : g_shift_col
    for (genvar r = 0; r < 4; r++) begin : g_shift_row
      assign shift_rows[127-8*(4*c+r) -: 8] = sub_bytes[127-8*(4*((c+r)%4)+r) -: 8];
    end
  end

  // MixColumns per column with the fixed {02,03,01,01} circulant matrix.
  for (genvar c = 0; c < 4; c++) begin : g_mix_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = shift_rows[127-32*c    -: 8];
    assign a1 = shift_rows[127-32*c-8  -: 8];
    assign a2 = shift_rows[127-32*c-16 -: 8];
    assign a3 = shift_rows[127-32*c-24 -: 8];
    assign mix_cols[127-32*c    -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign mix_cols[127-32*c-8  -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign mix_cols[127-32*c-16 -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign mix_cols[127-32*c-24 -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  // Key expansion: SubWord(RotWord(w3)) through the four key-path S-boxes.
  assign rot_word = {rkey[23:0], rkey[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sub_word
    aes_sbox u_sbox (
      .a (rot_word[31-8*i -: 8]),
      .y (sub_word[31-8*i -: 8])
    );
  end

  // Round constant for the round currently being computed.
  always_comb begin
    rcon = 8'h00;
    case (round)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign w0_n      = rkey[127:96] ^ sub_word ^ {rcon, 24'h000000};
  assign w1_n      = rkey[95:64]  ^ w0_n;
  assign w2_n      = rkey[63:32]  ^ w1_n;
  assign w3_n      = rkey[31:0]   ^ w2_n;
  assign next_rkey = {w0_n, w1_n, w2_n, w3_n};

  // Control and datapath registers: ld always restarts, RUN advances one round per edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm      <= IDLE;
      round    <= 4'd0;
      state    <= '0;
      rkey     <= '0;
      text_out <= '0;
      done     <= 1'b0;
    end else if (ld) begin
      fsm   <= RUN;
      round <= 4'd1;
      state <= text_in ^ key;
      rkey  <= key;
      done  <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          done <= 1'b0;
        end
        RUN: begin
          rkey <= next_rkey;
          if (round == 4'd10) begin
            text_out <= shift_rows ^ next_rkey;
            done     <= 1'b1;
            round    <= 4'd0;
            fsm      <= IDLE;
          end else begin
            state <= mix_cols ^ next_rkey;
            round <= round + 4'd1;
            done  <= 1'b0;
          end
        end
        default: begin
          fsm  <= IDLE;
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_cipher_top.sv
// tb/tb_aes_cipher_top.sv - scoreboard bench for aes_cipher_top using FIPS-197 vectors
module tb_aes_cipher_top;

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CT_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk;
  logic         rst;
  logic         ld;
  logic         done;
  logic [127:0] key;
  logic [127:0] text_in;
  logic [127:0] text_out;

  typedef struct {
    logic [127:0] exp;
    int           ld_cyc;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int        cyc;
  int        n_pass;
  int        n_total;
  logic      prev_done;

  aes_cipher_top dut (
    .clk      (clk),
    .rst      (rst),
    .ld       (ld),
    .done     (done),
    .key      (key),
    .text_in  (text_in),
    .text_out (text_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Register an expectation for a load sampled at the next edge; blocks it aborts are dropped.
  task automatic push_expect(input logic [127:0] exp);
    sb_entry_t e;
    int s;
    s = cyc + 1;
    while (sb_q.size() > 0 && sb_q[$].ld_cyc + 10 >= s) void'(sb_q.pop_back());
    e.exp    = exp;
    e.ld_cyc = s;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [127:0] k, input logic [127:0] pt, input logic [127:0] exp);
    key     = k;
    text_in = pt;
    ld      = 1'b1;
    push_expect(exp);
    step();
    ld = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step();
    check_eq("missing_done", 128'(sb_q.size()), 128'd0);
  endtask

  // Completion monitor: every done pulse must match the oldest expectation, arrive 10 cycles after its ld, and last one cycle.
  always @(negedge clk) begin
    sb_entry_t e;
    if (done) begin
      if (prev_done) check_eq("done_width", {127'd0, prev_done}, 128'd0);
      if (sb_q.size() == 0) begin
        check_eq("spurious_done", {127'd0, done}, 128'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("ciphertext", text_out, e.exp);
        check_eq("latency", 128'(cyc - e.ld_cyc), 128'd10);
      end
    end
    prev_done = done;
  end

  initial begin
    cyc       = 0;
    n_pass    = 0;
    n_total   = 0;
    prev_done = 1'b0;
    rst       = 1'b0;
    ld        = 1'b0;
    key       = '0;
    text_in   = '0;

    step();
    step();
    check_eq("reset_text_out", text_out, 128'd0);
    check_eq("reset_done", {127'd0, done}, 128'd0);
    rst = 1'b1;
    step();
    check_eq("idle_done", {127'd0, done}, 128'd0);

    load(KEY_C1, PT_C1, CT_C1);
    drain(12);
    load(KEY_B, PT_B, CT_B);
    drain(12);
    load('0, '0, CT_Z);
    drain(12);

    // ld while busy: only the second block may complete
    load(KEY_B, PT_B, CT_B);
    for (int i = 0; i < 4; i++) step();
    load(KEY_C1, PT_C1, CT_C1);
    drain(14);
    check_eq("abort_text_out", text_out, CT_C1);

    // reset sampled 4 edges after the ld edge
    load(KEY_B, PT_B, CT_B);
    for (int i = 0; i < 3; i++) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    sb_q.delete();
    check_eq("midrst_text_out", text_out, 128'd0);
    check_eq("midrst_done", {127'd0, done}, 128'd0);
    drain(14);
    check_eq("post_rst_idle", text_out, 128'd0);
    load(KEY_C1, PT_C1, CT_C1);
    drain(12);

    // inputs wander during rounds; result must be unaffected
    load(KEY_B, PT_B, CT_B);
    for (int i = 0; i < 10; i++) begin
      key     = {$urandom, $urandom, $urandom, $urandom};
      text_in = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    drain(2);
    for (int i = 0; i < 3; i++) begin
      key     = {$urandom, $urandom, $urandom, $urandom};
      text_in = {$urandom, $urandom, $urandom, $urandom};
      step();
      check_eq("hold_text_out", text_out, CT_B);
    end

    // ld held for three edges: completion counts from the last one
    key     = KEY_C1;
    text_in = PT_C1;
    ld      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_expect(CT_C1);
      step();
      check_eq("held_ld_done", {127'd0, done}, 128'd0);
    end
    ld = 1'b0;
    check_eq("held_ld_keeps_out", text_out, CT_B);
    drain(13);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
